hazard_forward_ctrl: RTL and testbench

//  Parametrised successor to the LC-3b forwarding logic. It sits at the ID/EX boundary and keeps a shadow

---
 rtl/hazard_forward_ctrl.sv | 103 ++++++++++
 tb/tb_hazard_forward_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// ID/EX forwarding and load-use control with a shadow scoreboard of in-flight destinations.
// Optional statistics counters are built when HAZARD_FWD_STATS_EN is defined.

module hazard_fwd_lane #(
  parameter int REG_W = 3,
  parameter int DEPTH = 3,
  parameter int SEL_W = 2
) (
  input  logic                        req,
  input  logic [REG_W-1:0]            src,
  input  logic [DEPTH-1:0]            slot_hit_en,
  input  logic [DEPTH-1:0][REG_W-1:0] slot_dr,
  output logic [SEL_W-1:0]            code
);
  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    code = '0;
    if (req)
      for (int s = DEPTH-1; s >= 0; s--)
        if (slot_hit_en[s] && slot_dr[s] == src) code = SEL_W'(s+1);
  end
endmodule

module hazard_forward_ctrl #(
  parameter int REG_W   = 3,
  parameter int NUM_SRC = 3,
  parameter int DEPTH   = 3,
  parameter int CNT_W   = 16,
  localparam int SEL_W  = $clog2(DEPTH+1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     advance,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic                     id_regwrite,
  input  logic                     id_is_load,
  input  logic [REG_W-1:0]         id_dr,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]       id_src_used,
  output logic                     stall,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel
`ifdef HAZARD_FWD_STATS_EN
 ,output logic [CNT_W-1:0]         stall_count,
  output logic [CNT_W-1:0]         fwd_count
`endif
);
  logic [DEPTH-1:0]              vld_pipe, rw_pipe, ld_pipe;
  logic [DEPTH-1:0][REG_W-1:0]   dr_pipe;
  logic [NUM_SRC-1:0][SEL_W-1:0] code, fwd_q;
  logic                          load_use, accept;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    hazard_fwd_lane #(.REG_W(REG_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_lane (
      .req        (id_valid & id_src_used[i]),
      .src        (id_src[i*REG_W +: REG_W]),
      .slot_hit_en(vld_pipe & rw_pipe),
      .slot_dr    (dr_pipe),
      .code       (code[i])
    );
  end

  // Code 1 means the youngest producer is in EX; a load there has no value yet.
  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (code[i] == SEL_W'(1) && ld_pipe[0]) load_use = 1'b1;
  end

  assign stall   = id_valid & ~flush & load_use;
  assign accept  = ~flush & ~stall;
  assign fwd_sel = fwd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      rw_pipe  <= '0;
      ld_pipe  <= '0;
      dr_pipe  <= '0;
      fwd_q    <= '0;
    end else if (advance) begin
      vld_pipe <= {vld_pipe[DEPTH-2:0], accept & id_valid};
      rw_pipe  <= {rw_pipe[DEPTH-2:0], id_regwrite};
      ld_pipe  <= {ld_pipe[DEPTH-2:0], id_is_load};
      dr_pipe  <= {dr_pipe[DEPTH-2:0], id_dr};
      fwd_q    <= accept ? code : '0;
    end
  end

`ifdef HAZARD_FWD_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      fwd_count   <= '0;
    end else if (advance) begin
      if (stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
      if (accept && (|code) && !(&fwd_count)) fwd_count <= fwd_count + 1'b1;
    end
  end
`else
  // Statistics not built.
`endif
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: producer-history model plus literal checkpoints.
module tb_hazard_forward_ctrl;
  localparam int DEPTH = 3;
  localparam int NSRC  = 3;

  logic       clk = 0, reset = 1, advance = 1, flush = 0;
  logic       id_valid = 0, id_regwrite = 0, id_is_load = 0;
  logic [2:0] id_dr = 0, id_src_used = 0;
  logic [8:0] id_src = 0;
  logic       stall;
  logic [5:0] fwd_sel;
`ifdef HAZARD_FWD_STATS_EN
  logic [15:0] stall_count, fwd_count;
  int m_sc, m_fc;
`endif

  int checks = 0, errors = 0;

  hazard_forward_ctrl dut (
    .clk(clk), .reset(reset), .advance(advance), .flush(flush),
    .id_valid(id_valid), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .id_dr(id_dr), .id_src(id_src), .id_src_used(id_src_used),
    .stall(stall), .fwd_sel(fwd_sel)
`ifdef HAZARD_FWD_STATS_EN
   ,.stall_count(stall_count), .fwd_count(fwd_count)
`endif
  );

  always #5 clk = ~clk;

  // History of instructions that left ID, index 0 = most recent (in EX).
  typedef struct { bit v; bit rw; bit ld; bit [2:0] dr; } ent_t;
  ent_t m_slot [DEPTH];
  int   m_fwd  [NSRC];

  function automatic int m_code(int i);
    if (!id_valid || !id_src_used[i]) return 0;
    for (int s = 0; s < DEPTH; s++)
      if (m_slot[s].v && m_slot[s].rw && m_slot[s].dr == id_src[i*3 +: 3]) return s + 1;
    return 0;
  endfunction

  function automatic bit m_stall();
    if (!id_valid || flush) return 0;
    for (int i = 0; i < NSRC; i++)
      if (m_code(i) == 1 && m_slot[0].ld) return 1;
    return 0;
  endfunction

  function automatic bit m_anyfwd();
    for (int i = 0; i < NSRC; i++) if (m_code(i) != 0) return 1;
    return 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) m_slot[s] <= '{0, 0, 0, 3'd0};
      for (int i = 0; i < NSRC; i++) m_fwd[i] <= 0;
`ifdef HAZARD_FWD_STATS_EN
      m_sc <= 0; m_fc <= 0;
`endif
    end else if (advance) begin
      for (int s = 1; s < DEPTH; s++) m_slot[s] <= m_slot[s-1];
      if (flush || m_stall()) begin
        m_slot[0] <= '{0, 0, 0, 3'd0};
        for (int i = 0; i < NSRC; i++) m_fwd[i] <= 0;
      end else begin
        m_slot[0] <= '{id_valid, id_regwrite, id_is_load, id_dr};
        for (int i = 0; i < NSRC; i++) m_fwd[i] <= m_code(i);
      end
`ifdef HAZARD_FWD_STATS_EN
      if (m_stall() && m_sc < 65535) m_sc <= m_sc + 1;
      if (!flush && !m_stall() && m_anyfwd() && m_fc < 65535) m_fc <= m_fc + 1;
`endif
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (stall !== m_stall()) begin
        errors++;
        $display("FAIL model_stall t=%0t got %0b expected %0b", $time, stall, m_stall());
      end
      for (int i = 0; i < NSRC; i++) begin
        checks++;
        if (int'(fwd_sel[i*2 +: 2]) != m_fwd[i]) begin
          errors++;
          $display("FAIL model_fwd src%0d t=%0t got %0d expected %0d", i, $time, fwd_sel[i*2 +: 2], m_fwd[i]);
        end
      end
`ifdef HAZARD_FWD_STATS_EN
      checks++;
      if (int'(stall_count) != m_sc || int'(fwd_count) != m_fc) begin
        errors++;
        $display("FAIL model_cnt got %0d/%0d expected %0d/%0d", stall_count, fwd_count, m_sc, m_fc);
      end
`endif
    end
  end

  task automatic lit(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit rw, input bit ld, input int dr,
                       input int s0, input int s1, input int s2, input int used);
    id_valid = v; id_regwrite = rw; id_is_load = ld; id_dr = 3'(dr);
    id_src = {3'(s2), 3'(s1), 3'(s0)}; id_src_used = 3'(used);
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
  endtask

  task automatic clear();
    repeat (3) nop();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    lit("reset_stall", int'(stall), 0);
    lit("reset_fwd", int'(fwd_sel), 0);

    // 1: ALU back to back
    drive(1, 1, 0, 1, 0, 0, 0, 3'b011); tick();
    drive(1, 1, 0, 2, 1, 1, 0, 3'b011);
    lit("t1_stall", int'(stall), 0); tick();
    lit("t1_fwd", int'(fwd_sel), 6'b000101);

    // 2: load-use
    clear();
    drive(1, 1, 1, 3, 2, 0, 0, 3'b001); tick();
    drive(1, 1, 0, 4, 3, 0, 0, 3'b011);
    lit("t2_stall", int'(stall), 1); tick();
    lit("t2_bubble_fwd", int'(fwd_sel), 0);
    lit("t2_stall_gone", int'(stall), 0); tick();
    lit("t2_fwd", int'(fwd_sel), 6'b000010);

    // 3: WB forwarding to a store source, then out of range
    clear();
    drive(1, 1, 0, 5, 1, 2, 0, 3'b011); tick();
    nop(); nop();
    drive(1, 0, 0, 0, 6, 0, 5, 3'b101); tick();
    lit("t3_wb_fwd", int'(fwd_sel), 6'b110000);
    clear();
    drive(1, 1, 0, 5, 1, 2, 0, 3'b011); tick();
    nop(); nop(); nop();
    drive(1, 0, 0, 0, 6, 0, 5, 3'b101); tick();
    lit("t3_retired", int'(fwd_sel), 0);

    // 4: youngest wins
    clear();
    drive(1, 1, 0, 1, 0, 0, 0, 3'b011); tick();
    drive(1, 1, 0, 1, 2, 0, 0, 3'b011); tick();
    drive(1, 1, 0, 6, 1, 0, 0, 3'b001); tick();
    lit("t4_youngest", int'(fwd_sel), 6'b000001);

    // 5: flush beats load-use
    clear();
    drive(1, 1, 1, 3, 2, 0, 0, 3'b001); tick();
    flush = 1;
    drive(1, 1, 0, 4, 3, 3, 0, 3'b011);
    lit("t5_stall", int'(stall), 0); tick();
    flush = 0;
    lit("t5_fwd", int'(fwd_sel), 0);
    drive(1, 1, 0, 7, 3, 0, 0, 3'b001);
    lit("t5_no_stall", int'(stall), 0); tick();
    lit("t5_after", int'(fwd_sel), 6'b000010);

    // 6: hold during load-use, then async reset mid-stream
    clear();
    drive(1, 1, 0, 4, 0, 0, 0, 3'b001); tick();
    drive(1, 1, 1, 3, 4, 0, 0, 3'b001); tick();
    lit("t6_ld_fwd", int'(fwd_sel), 1);
    drive(1, 1, 0, 6, 3, 0, 0, 3'b001);
    advance = 0;
    for (int k = 0; k < 3; k++) begin
      lit("t6_hold_stall", int'(stall), 1); tick();
      lit("t6_hold_fwd", int'(fwd_sel), 1);
    end
    advance = 1;
    lit("t6_stall", int'(stall), 1); tick();
    lit("t6_bubble", int'(fwd_sel), 0);
    lit("t6_stall_gone", int'(stall), 0); tick();
    lit("t6_fwd", int'(fwd_sel), 6'b000010);
    drive(1, 1, 1, 3, 6, 0, 0, 3'b001); tick();
    lit("t6_pre_fwd", int'(fwd_sel), 1);
    drive(1, 1, 0, 2, 3, 0, 0, 3'b001);
    lit("t6_pre_stall", int'(stall), 1);
    reset = 1; #1;
    lit("t6_rst_stall", int'(stall), 0);
    lit("t6_rst_fwd", int'(fwd_sel), 0);
    tick();
    reset = 0;
    drive(1, 1, 0, 2, 3, 0, 0, 3'b001); tick();
    lit("t6_post_rst", int'(fwd_sel), 0);
    clear();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
